// File: rtl/sr_input_conditioner.sv
// rtl/sr_input_conditioner.sv - synchronise and debounce raw set/reset requests into S/R latch drives
// Compile-time option SR_COND_PULSE_EN: one-cycle S/R pulses on accepted rises instead of levels.
module sr_input_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic set_raw,
  input  logic rst_raw,
  output logic S,
  output logic R,
  output logic conflict
);

  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_set_q;
  logic [SYNC_STAGES-1:0] sync_rst_q;
  logic                   sync_set;
  logic                   sync_rst;
  logic                   db_set;
  logic                   db_rst;
  logic [CW-1:0]          cnt_set;
  logic [CW-1:0]          cnt_rst;
  logic [CW:0]            nxt_set;
  logic [CW:0]            nxt_rst;

  assign sync_set = sync_set_q[SYNC_STAGES-1];
  assign sync_rst = sync_rst_q[SYNC_STAGES-1];

  // Returns {next_db, next_cnt}: the level flips only after DEBOUNCE_CNT consecutive disagreeing samples.
  function automatic logic [CW:0] debounce_next(input logic s, input logic db, input logic [CW-1:0] cnt);
    if (s == db) begin
      return {db, {CW{1'b0}}};
    end else if (cnt == CNT_MAX) begin
      return {s, {CW{1'b0}}};
    end else begin
      return {db, cnt + CW'(1)};
    end
  endfunction

  always_comb begin
    nxt_set = debounce_next(sync_set, db_set, cnt_set);
    nxt_rst = debounce_next(sync_rst, db_rst, cnt_rst);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_set_q <= '0;
      sync_rst_q <= '0;
      db_set     <= 1'b0;
      db_rst     <= 1'b0;
      cnt_set    <= '0;
      cnt_rst    <= '0;
    end else begin
      sync_set_q <= {sync_set_q[SYNC_STAGES-2:0], set_raw};
      sync_rst_q <= {sync_rst_q[SYNC_STAGES-2:0], rst_raw};
      db_set     <= nxt_set[CW];
      cnt_set    <= nxt_set[CW-1:0];
      db_rst     <= nxt_rst[CW];
      cnt_rst    <= nxt_rst[CW-1:0];
    end
  end

`ifdef SR_COND_PULSE_EN
  // Previous debounced levels, used to find 0->1 transitions.
  logic db_set_d;
  logic db_rst_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_set_d <= 1'b0;
      db_rst_d <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      db_set_d <= db_set;
      db_rst_d <= db_rst;
      S        <= db_set & ~db_set_d & ~db_rst;
      R        <= db_rst & ~db_rst_d & ~db_set;
      conflict <= db_set & db_rst;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      S        <= db_set & ~db_rst;
      R        <= db_rst & ~db_set;
      conflict <= db_set & db_rst;
    end
  end
`endif

endmodule

// File: tb/tb_sr_input_conditioner.sv
// tb/tb_sr_input_conditioner.sv - self-checking bench for sr_input_conditioner
module tb_sr_input_conditioner;
  localparam int SS = 2;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset;
  logic set_raw;
  logic rst_raw;
  logic S;
  logic R;
  logic conflict;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sr_input_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CNT(DC)) dut (
    .clk(clk),
    .reset(reset),
    .set_raw(set_raw),
    .rst_raw(rst_raw),
    .S(S),
    .R(R),
    .conflict(conflict)
  );

  // Reference model: raw samples ride a delay queue, a channel flips once the
  // last DC delayed samples all disagree with its current level.
  bit m_pipe[2][$];
  bit m_win[2][$];
  bit m_db[2];
  bit m_prev[2];
  bit m_S, m_R, m_conf;

  function automatic void chan_step(int c, bit raw);
    bit sx;
    bit all_diff;
    sx = m_pipe[c].pop_front();
    m_pipe[c].push_back(raw);
    m_win[c].push_back(sx);
    if (m_win[c].size() > DC) void'(m_win[c].pop_front());
    all_diff = (m_win[c].size() == DC);
    foreach (m_win[c][k]) if (m_win[c][k] == m_db[c]) all_diff = 1'b0;
    if (all_diff) begin
      m_db[c] = ~m_db[c];
      m_win[c].delete();
    end
  endfunction

  always @(posedge clk) begin : model
    bit db_old[2];
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_pipe[c].delete();
        for (int k = 0; k < SS; k++) m_pipe[c].push_back(1'b0);
        m_win[c].delete();
        m_db[c] = 1'b0;
        m_prev[c] = 1'b0;
      end
      m_S = 1'b0; m_R = 1'b0; m_conf = 1'b0;
    end else begin
      db_old = m_db;
`ifdef SR_COND_PULSE_EN
      m_S = db_old[0] && !m_prev[0] && !db_old[1];
      m_R = db_old[1] && !m_prev[1] && !db_old[0];
`else
      m_S = db_old[0] && !db_old[1];
      m_R = db_old[1] && !db_old[0];
`endif
      m_conf = db_old[0] && db_old[1];
      chan_step(0, set_raw);
      chan_step(1, rst_raw);
      m_prev = db_old;
    end
  end

  typedef struct {
    bit       rs;
    bit       s;
    bit       r;
    bit [2:0] exp;  // {S, R, conflict}
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rs, bit s, bit r, int n, bit [2:0] e);
    vec_t v;
    v.rs = rs; v.s = s; v.r = r; v.exp = e;
    repeat (n) vecs.push_back(v);
  endfunction

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(bit rs, bit s, bit r);
    reset = rs; set_raw = s; rst_raw = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int first;
    bit rs_s, rs_r, rs_rst;
    reset = 1'b1; set_raw = 1'b0; rst_raw = 1'b0;
    @(negedge clk);

`ifndef SR_COND_PULSE_EN
    // Level-mode sequence: reset with raws high, accept set, then rst, drop set, drop rst, both together.
    add(1, 1, 1, 2, 3'b000);
    add(0, 1, 0, 6, 3'b000); add(0, 1, 0, 3, 3'b100);
    add(0, 1, 1, 6, 3'b100); add(0, 1, 1, 2, 3'b001);
    add(0, 0, 1, 6, 3'b001); add(0, 0, 1, 2, 3'b010);
    add(0, 0, 0, 6, 3'b010); add(0, 0, 0, 1, 3'b000);
    add(0, 1, 1, 6, 3'b000); add(0, 1, 1, 2, 3'b001);
    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].s, vecs[i].r);
      check($sformatf("vec%0d_S", i), S, vecs[i].exp[2]);
      check($sformatf("vec%0d_R", i), R, vecs[i].exp[1]);
      check($sformatf("vec%0d_conflict", i), conflict, vecs[i].exp[0]);
    end

    // A 3-cycle pulse is rejected; a 4-cycle pulse gives S high for 4 cycles starting at edge 7.
    drive(1, 0, 0); drive(1, 0, 0);
    for (int i = 0; i < 18; i++) begin
      drive(0, i < 3, 0);
      check($sformatf("short_pulse_S%0d", i), S, 1'b0);
    end
    cnt = 0; first = -1;
    for (int i = 0; i < 25; i++) begin
      drive(0, i < 4, 0);
      if (S === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check_int("pulse4_S_cycles", cnt, 4);
    check_int("pulse4_S_first_edge", first + 1, 7);

    // rst_raw chatters every cycle while set_raw is held: R never asserts, S follows set only.
    drive(1, 0, 0); drive(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, (i % 2) == 0);
      check($sformatf("bounce_R%0d", i), R, 1'b0);
      check($sformatf("bounce_conflict%0d", i), conflict, 1'b0);
      check($sformatf("bounce_S%0d", i), S, i >= 6);
    end

    // Reset mid-count discards progress; the full latency restarts after release.
    drive(1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0);
    drive(1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0);
      check($sformatf("midcount_reset_S%0d", i), S, i >= 6);
    end
`else
    // Pulse mode: held set gives one pulse at edge 7; simultaneous rises give no pulse.
    drive(1, 0, 0); drive(1, 0, 0);
    cnt = 0; first = -1;
    for (int i = 0; i < 50; i++) begin
      drive(0, 1, 0);
      if (S === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
      check($sformatf("pulse_R%0d", i), R, 1'b0);
    end
    check_int("pulse_S_cycles", cnt, 1);
    check_int("pulse_S_first_edge", first + 1, 7);
    drive(1, 0, 0); drive(1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 1);
      check($sformatf("both_S%0d", i), S, 1'b0);
      check($sformatf("both_R%0d", i), R, 1'b0);
      check($sformatf("both_conflict%0d", i), conflict, i >= 6);
    end
`endif

    // Randomised run against the reference model.
    rs_s = 1'b0; rs_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rs_s = ~rs_s;
      if ($urandom_range(0, 5) == 0) rs_r = ~rs_r;
      rs_rst = ($urandom_range(0, 299) == 0);
      drive(rs_rst, rs_s, rs_r);
      check($sformatf("rand%0d_S", i), S, m_S);
      check($sformatf("rand%0d_R", i), R, m_R);
      check($sformatf("rand%0d_conflict", i), conflict, m_conf);
      check($sformatf("rand%0d_S_and_R", i), S & R, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
